// File: rtl/sipo_frame_rx_amisha.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_rx_amisha
// Description : Strobe-qualified serial-to-parallel frame receiver.
//               A frame is one start bit (0), DATA_WIDTH data bits (LSB
//               first) and one stop bit (1). Bits are taken only on clock
//               edges where en_amisha is high. Each good word is presented
//               on a valid/ready handshake. Bad stop bits give a one-cycle
//               frame_err_amisha pulse. A good frame that arrives while the
//               previous word is still pending sets the sticky
//               overrun_amisha flag.
// Ports       : clk_amisha       - rising-edge clock
//               reset_amisha     - synchronous reset, active low
//               en_amisha        - bit strobe
//               d_amisha         - serial data line (idles high)
//               ready_amisha     - consumer accepts data when valid is high
//               data_amisha      - last loaded word
//               valid_amisha     - data_amisha not yet consumed
//               busy_amisha      - frame in progress
//               frame_err_amisha - one-cycle pulse on a bad stop bit
//               overrun_amisha   - sticky dropped-frame flag
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_rx_amisha #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_amisha,
    input  logic                  reset_amisha,
    input  logic                  en_amisha,
    input  logic                  d_amisha,
    input  logic                  ready_amisha,
    output logic [DATA_WIDTH-1:0] data_amisha,
    output logic                  valid_amisha,
    output logic                  busy_amisha,
    output logic                  frame_err_amisha,
    output logic                  overrun_amisha
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_DATA = 2'd1;
    localparam logic [1:0] c_STOP = 2'd2;

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_frame_err;
    logic                  r_overrun;

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            // Handshake runs every cycle, independent of the strobe. A word
            // loaded on a stop-bit edge below overrides this clear.
            if (r_valid && ready_amisha) begin
                r_valid <= 1'b0;
            end

            if (en_amisha) begin
                case (r_state)
                    c_IDLE: begin
                        if (!d_amisha) begin
                            r_state <= c_DATA;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                        end
                    end

                    c_DATA: begin
                        r_sr <= {d_amisha, r_sr[DATA_WIDTH-1:1]};
                        // Hold the counter on the last data bit so it never
                        // wraps when DATA_WIDTH is a power of two.
                        if (r_cnt == c_LAST_BIT) begin
                            r_state <= c_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    c_STOP: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                        if (d_amisha) begin
                            // Load if nothing is pending, or if the pending
                            // word is consumed on this very edge.
                            if (!r_valid || ready_amisha) begin
                                r_data  <= r_sr;
                                r_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end

                    default: begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_amisha      = r_data;
    assign valid_amisha     = r_valid;
    assign busy_amisha      = r_busy;
    assign frame_err_amisha = r_frame_err;
    assign overrun_amisha   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_rx_amisha.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_frame_rx_amisha
// Description : Self-checking bench for sipo_frame_rx_amisha. Stimulus tasks
//               drive frames and keep a frame-level reference model; a
//               negedge monitor compares every output against that model and
//               pops the expected-word queue on each handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_frame_rx_amisha;

    localparam int W = 8;

    logic         clk_amisha = 1'b0;
    logic         reset_amisha;
    logic         en_amisha;
    logic         d_amisha;
    logic         ready_amisha;
    logic [W-1:0] data_amisha;
    logic         valid_amisha;
    logic         busy_amisha;
    logic         frame_err_amisha;
    logic         overrun_amisha;

    sipo_frame_rx_amisha #(.DATA_WIDTH(W)) dut (
        .clk_amisha      (clk_amisha),
        .reset_amisha    (reset_amisha),
        .en_amisha       (en_amisha),
        .d_amisha        (d_amisha),
        .ready_amisha    (ready_amisha),
        .data_amisha     (data_amisha),
        .valid_amisha    (valid_amisha),
        .busy_amisha     (busy_amisha),
        .frame_err_amisha(frame_err_amisha),
        .overrun_amisha  (overrun_amisha)
    );

    always #5 clk_amisha = ~clk_amisha;

    int tests = 0;
    int fails = 0;

    // Frame-level reference model
    logic [W-1:0] exp_q[$];     // loaded words awaiting consumption, in order
    logic [W-1:0] m_data  = '0; // last loaded word
    logic [W-1:0] m_frame = '0; // word of the frame being sent
    bit           m_valid = 0;
    bit           m_busy  = 0;
    bit           m_ovr   = 0;
    int           err_pending = 0;
    int           accepted = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pick(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    // kind: 0 = no frame event, 1 = start bit, 2 = stop bit
    task automatic strobe(input bit en, input bit d, input bit rdy, input int kind);
        en_amisha    = en;
        d_amisha     = d;
        ready_amisha = rdy;
        @(posedge clk_amisha);
        #1;
        if (en && kind == 1) m_busy = 1;
        if (en && kind == 2) begin
            m_busy = 0;
            if (d) begin
                if (!m_valid || rdy) begin
                    exp_q.push_back(m_frame);
                    m_data  = m_frame;
                    m_valid = 1;
                end else begin
                    m_ovr = 1;
                    if (m_valid && rdy) m_valid = 0;
                end
            end else begin
                err_pending++;
                if (m_valid && rdy) m_valid = 0;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic gaps(input int n, input int rmode);
        repeat (n) strobe(1'b0, bit'($urandom_range(0, 1)), pick(rmode), 0);
    endtask

    task automatic send_frame(input logic [W-1:0] data, input bit stop, input int gap,
                              input int rmode, input int srmode);
        m_frame = data;
        strobe(1'b1, 1'b0, pick(rmode), 1);
        gaps(gap, rmode);
        for (int i = 0; i < W; i++) begin
            strobe(1'b1, data[i], pick(rmode), 0);
            gaps(gap, rmode);
        end
        strobe(1'b1, stop, pick(srmode), 2);
    endtask

    task automatic reset_dut();
        en_amisha    = 1'b0;
        d_amisha     = 1'b1;
        ready_amisha = 1'b0;
        reset_amisha = 1'b0;
        @(posedge clk_amisha);
        #1;
        reset_amisha = 1'b1;
        exp_q.delete();
        m_data = '0; m_valid = 0; m_busy = 0; m_ovr = 0; err_pending = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_data", 32'(data_amisha), 32'h0);
        chk("rst_valid", 32'(valid_amisha), 32'h0);
        chk("rst_busy", 32'(busy_amisha), 32'h0);
        chk("rst_ferr", 32'(frame_err_amisha), 32'h0);
        chk("rst_ovr", 32'(overrun_amisha), 32'h0);
    endtask

    // Monitor: compare outputs against the model mid-cycle
    always @(negedge clk_amisha) begin
        chk("mon_valid", 32'(valid_amisha), 32'(m_valid));
        chk("mon_data", 32'(data_amisha), 32'(m_data));
        chk("mon_busy", 32'(busy_amisha), 32'(m_busy));
        chk("mon_ovr", 32'(overrun_amisha), 32'(m_ovr));
        chk("mon_ferr", 32'(frame_err_amisha), 32'(err_pending > 0));
        if (frame_err_amisha && err_pending > 0) err_pending--;
        if (valid_amisha && ready_amisha && exp_q.size() > 0) begin
            chk("accept_word", 32'(data_amisha), 32'(exp_q.pop_front()));
            accepted++;
        end
    end

    initial begin
        int snap;
        reset_amisha = 1'b0;
        en_amisha    = 1'b0;
        d_amisha     = 1'b1;
        ready_amisha = 1'b0;
        @(posedge clk_amisha); #1;
        @(posedge clk_amisha); #1;
        reset_amisha = 1'b1;
        chk_reset_vals();

        // Basic frame
        send_frame(8'hA5, 1'b1, 0, 0, 0);
        chk("basic_data", 32'(data_amisha), 32'hA5);
        chk("basic_valid", 32'(valid_amisha), 32'h1);
        chk("basic_busy", 32'(busy_amisha), 32'h0);

        // Handshake and gapped strobes
        strobe(1'b0, 1'b1, 1'b1, 0);
        chk("hs_drop1", 32'(valid_amisha), 32'h0);
        send_frame(8'hA5, 1'b1, 3, 0, 0);
        chk("gap_data", 32'(data_amisha), 32'hA5);
        chk("gap_valid", 32'(valid_amisha), 32'h1);
        strobe(1'b0, 1'b1, 1'b1, 0);
        chk("hs_drop2", 32'(valid_amisha), 32'h0);

        // Framing error
        send_frame(8'h3C, 1'b0, 0, 0, 0);
        chk("ferr_pulse", 32'(frame_err_amisha), 32'h1);
        chk("ferr_busy", 32'(busy_amisha), 32'h0);
        strobe(1'b0, 1'b1, 1'b0, 0);
        chk("ferr_one_cycle", 32'(frame_err_amisha), 32'h0);
        chk("ferr_valid", 32'(valid_amisha), 32'h0);
        chk("ferr_data", 32'(data_amisha), 32'hA5);

        // Overrun
        send_frame(8'h11, 1'b1, 0, 0, 0);
        send_frame(8'h22, 1'b1, 0, 0, 0);
        chk("ovr_data", 32'(data_amisha), 32'h11);
        chk("ovr_flag", 32'(overrun_amisha), 32'h1);
        strobe(1'b0, 1'b1, 1'b0, 0);
        chk("ovr_sticky", 32'(overrun_amisha), 32'h1);
        reset_dut();
        chk_reset_vals();
        send_frame(8'h11, 1'b1, 0, 0, 0);
        send_frame(8'h22, 1'b1, 0, 0, 1);
        chk("ovr_rdy_data", 32'(data_amisha), 32'h22);
        chk("ovr_rdy_valid", 32'(valid_amisha), 32'h1);
        chk("ovr_rdy_flag", 32'(overrun_amisha), 32'h0);
        strobe(1'b0, 1'b1, 1'b1, 0);

        // Reset mid-frame
        m_frame = 8'h5A;
        strobe(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) strobe(1'b1, m_frame[i], 1'b0, 0);
        chk("mid_busy", 32'(busy_amisha), 32'h1);
        reset_dut();
        chk_reset_vals();
        send_frame(8'hFF, 1'b1, 0, 0, 0);
        chk("ff_data", 32'(data_amisha), 32'hFF);
        chk("ff_valid", 32'(valid_amisha), 32'h1);
        strobe(1'b0, 1'b1, 1'b1, 0);

        // Idle line, then back-to-back frames
        snap = accepted;
        repeat (20) strobe(1'b1, 1'b1, 1'b1, 0);
        chk("idle_busy", 32'(busy_amisha), 32'h0);
        chk("idle_valid", 32'(valid_amisha), 32'h0);
        send_frame(8'h00, 1'b1, 0, 1, 1);
        send_frame(8'h80, 1'b1, 0, 1, 1);
        chk("b2b_data", 32'(data_amisha), 32'h80);
        strobe(1'b0, 1'b1, 1'b1, 0);
        strobe(1'b0, 1'b1, 1'b1, 0);
        chk("b2b_count", 32'(accepted - snap), 32'd2);

        // Randomized traffic
        reset_dut();
        for (int f = 0; f < 40; f++) begin
            logic [W-1:0] rd;
            rd = W'($urandom);
            send_frame(rd, ($urandom_range(0, 7) != 0), $urandom_range(0, 2), 2, 2);
            if ($urandom_range(0, 3) == 0) strobe(1'b1, 1'b1, pick(2), 0);
        end
        repeat (3) strobe(1'b0, 1'b1, 1'b1, 0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_frame_rx_amisha.md
# sipo_frame_rx_amisha

- Receives a strobe-qualified serial frame and delivers it as a parallel word:
  - the frame is one start bit (0), DATA_WIDTH data bits sent LSB first, then one stop bit (1);
  - each bit is sampled only on a clock edge where the enable strobe is high.
- Sits at the receiving end of the team's enable-gated serial links, downstream of the D-flip-flop/enable transmit path.
- Presents each received word on a valid/ready handshake and flags framing errors and overruns.

## Interface

- DATA_WIDTH, default 8: data bits per frame; legal values are 2 to 32.
- clk_amisha, input, 1: single clock; everything is rising-edge.
- reset_amisha, input, 1: synchronous, active-low reset.
- en_amisha, input, 1: bit strobe. d_amisha is sampled only on edges where this is 1.
- d_amisha, input, 1: serial data line; it idles at 1.
- ready_amisha, input, 1: the consumer accepts data_amisha on an edge where valid_amisha and ready_amisha are both 1.
- data_amisha, output, DATA_WIDTH: the last accepted word, held stable while valid_amisha is 1.
- valid_amisha, output, 1: data_amisha holds a word that has not yet been consumed.
- busy_amisha, output, 1: a frame is in progress (state is not IDLE).
- frame_err_amisha, output, 1: one-cycle pulse when a bad stop bit is sampled.
- overrun_amisha, output, 1: sticky flag; a completed frame was dropped because the previous word was still pending.

## Operation

- The state machine has three states: IDLE, DATA and STOP. State changes only on strobe edges (en_amisha=1). Reset and the handshake are the exceptions.
- IDLE:
  - strobe with d_amisha=0 goes to DATA and clears the bit counter;
  - strobe with d_amisha=1 stays in IDLE.
- DATA:
  - on each strobe the shift register becomes {d_amisha, sr[DATA_WIDTH-1:1]}, i.e. LSB-first assembly;
  - the counter increments on each strobe;
  - on the strobe where the counter equals DATA_WIDTH-1, go to STOP;
  - the counter is $clog2(DATA_WIDTH) bits and never wraps within a frame.
- STOP, on a strobe, always returning to IDLE:
  - d_amisha=1 and valid_amisha=0: load data_amisha from sr and set valid_amisha.
  - d_amisha=1, valid_amisha=1 and ready_amisha=1 on the same edge: the old word is consumed and the new word loads; valid_amisha stays 1 and no overrun is raised.
  - d_amisha=1, valid_amisha=1 and ready_amisha=0: the new word is discarded, data_amisha is unchanged, and overrun_amisha is set.
  - d_amisha=0: frame_err_amisha pulses high for exactly one cycle and the word is discarded; valid_amisha and data_amisha are unchanged.
- Handshake:
  - valid_amisha clears on an edge where valid_amisha=1, ready_amisha=1 and no new word loads;
  - ready_amisha has no effect while valid_amisha is 0.
- overrun_amisha stays set until reset.
- en_amisha=0 freezes the state, the counter and the shift register; the handshake still operates.

## Timing

- Values after a reset edge: state=IDLE, sr=0, counter=0, data_amisha=0, valid_amisha=0, busy_amisha=0, frame_err_amisha=0, overrun_amisha=0.
- Reset has priority over every other event. A reset in the middle of a frame aborts the frame with no flags raised.
- Latency:
  - valid_amisha rises one clock after the edge that samples a good stop bit;
  - frame_err_amisha is high in the cycle following the bad stop-bit edge.
- busy_amisha goes high the cycle after the start-bit edge and goes low the cycle after the stop-bit edge.
- A full frame needs DATA_WIDTH+2 strobes. Strobe spacing is arbitrary, and back-to-back strobes are legal.
- A new start bit is accepted on the strobe immediately following the stop-bit strobe.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use DATA_WIDTH=8.

- **Basic frame:** after reset, strobe the line 0,1,0,1,0,0,1,0,1,1 with ready_amisha=0.
  - Required: data_amisha=0xA5 and valid_amisha=1 one clock after the 10th strobe; busy_amisha=0.
- **Handshake and gaps:** repeat the basic frame with en_amisha low for 3 cycles between strobes, then pulse ready_amisha.
  - Required: the same 0xA5 result; valid_amisha drops the cycle after ready_amisha is sampled.
- **Framing error:** strobe the frame for 0x3C with a stop bit of 0.
  - Required: a one-cycle frame_err_amisha; valid_amisha=0; data_amisha keeps its previous value; busy_amisha=0.
- **Overrun:** send 0x11 and hold ready_amisha=0, then send 0x22.
  - Required: data_amisha=0x11 and overrun_amisha=1.
  - Repeat with ready_amisha=1 exactly on the 0x22 stop-bit edge. Required: data_amisha=0x22, valid_amisha=1, overrun_amisha=0.
- **Reset mid-frame:** assert reset_amisha=0 for one edge after 4 data bits.
  - Required: all outputs return to their reset values.
  - A subsequent full 0xFF frame is then received correctly.
- **Idle line:** 20 strobes with d_amisha=1, then 0x00 sent back-to-back with 0x80.
  - Required: no activity during the idle strobes; the two words arrive in order, 0x00 then 0x80, with ready_amisha=1.
